// File: rtl/switch_conditioner.sv
// Synchronises, debounces and one-hot-validates the front-panel mode switches.
// Latency: outputs update DEBOUNCE_CYCLES+3 edges after a new stable pin level; no backpressure.
module switch_conditioner #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] config_out,
    output logic             config_valid,
    output logic             config_strobe,
    output logic             config_error
);

    localparam logic [WIDTH-1:0]     OFF_LEVEL = {WIDTH{ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_EVAL  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     sync1_q, sync1_d;
    logic [WIDTH-1:0]     sync2_q, sync2_d;
    logic [WIDTH-1:0]     cand_q, cand_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 strobe_q, strobe_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0]     s;
    logic                 eval;
    logic                 cand_onehot;

    // Polarity is normalised after the synchroniser so both flops see raw pin levels.
    assign s           = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign cand_onehot = (cand_q != '0) && ((cand_q & (cand_q - WIDTH'(1))) == '0);

    always_comb begin
        sync1_d  = switch_raw;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        err_d    = err_q;
        eval     = 1'b0;

        if (s != cand_q) begin
            cand_d = s;
            cnt_d  = '0;
        end else begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            // Fires once per stable period: the counter moves past CNT_EVAL and then saturates.
            eval = (cnt_q == CNT_EVAL);
        end

        if (eval) begin
            if (cand_onehot) begin
                err_d = 1'b0;
                if (cand_q != out_q) begin
                    out_d    = cand_q;
                    strobe_d = 1'b1;
                    valid_d  = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= OFF_LEVEL;
            sync2_q  <= OFF_LEVEL;
            cand_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    assign config_out    = out_q;
    assign config_valid  = valid_q;
    assign config_strobe = strobe_q;
    assign config_error  = err_q;

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Front end of the mode-selection path: samples the five raw front-panel mode switches and produces the clean one-hot vector consumed by the configuration block's config_in.
- Raw pins are asynchronous, bouncy and possibly active-low. This block synchronises, debounces and validates them.
- It presents only stable, exactly-one-hot selections downstream, plus a change strobe and an error flag for the status display.

Parameters:
- WIDTH, 5, number of switch inputs.
- DEBOUNCE_CYCLES, 1000000, consecutive clock cycles the synchronised input must hold before it is evaluated. Legal range is 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of the debounce counter.
- ACTIVE_LOW, 1, when 1 a switch is "on" when its pin reads 0 (inversion applied after synchroniser).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- switch_raw  input  WIDTH  asynchronous raw switch pins.
- config_out  output  WIDTH  last accepted one-hot selection; drives configuration config_in.
- config_valid  output  1  high once any valid selection has been accepted since reset.
- config_strobe  output  1  one-cycle pulse when config_out takes a new value.
- config_error  output  1  high while the most recent evaluated stable pattern was zero-hot or multi-hot.

Behaviour:
- One clock domain and one reset. Reset is synchronous and active-high; every register below clears on a clock edge with reset=1.
- Reset values:
  - config_out=0, config_valid=0, config_strobe=0, config_error=0.
  - Debounce counter=0, candidate=0.
  - Both synchroniser flops load the "all switches off" pin level: all-ones if ACTIVE_LOW, else all-zeros.
- Synchroniser: two flops per bit. s = second flop, inverted bitwise if ACTIVE_LOW.
- Debounce, evaluated each edge (no reset):
  - s != candidate: candidate<=s, cnt<=0.
  - else if cnt < DEBOUNCE_CYCLES: cnt<=cnt+1.
  - else: cnt holds (saturates).
- Evaluation occurs exactly once per stable period, on the edge where s==candidate and cnt==DEBOUNCE_CYCLES-1. On that edge:
  - candidate exactly one bit set and != config_out: config_out<=candidate, config_strobe<=1, config_valid<=1, config_error<=0.
  - candidate exactly one bit set and == config_out: config_error<=0; no strobe; config_out unchanged.
  - candidate zero or more than one bit set: config_error<=1; config_out and config_valid hold.
- config_strobe is high for exactly one cycle per accepted change; it is 0 on every other edge.
- Latency: the edge that first samples a new stable pin level is edge 1; outputs update at edge DEBOUNCE_CYCLES+3 and are visible after it.
- Glitches: any change in s restarts the count. A pattern held in s for fewer than DEBOUNCE_CYCLES consecutive cycles is never evaluated.
- Multi-bit transitions (e.g. a switch-2 to switch-3 move passing through 0 or through 2+3): intermediate patterns are filtered if brief. If held, they set config_error without disturbing config_out.
- Reset mid-debounce: the pending candidate is discarded and all outputs return to reset values. Evaluation restarts from scratch, so no strobe occurs before DEBOUNCE_CYCLES+3 edges after reset deasserts.
- All-off switches after reset: evaluated like any pattern, giving config_error=1, config_valid=0, config_out=0.
- Counter never wraps (saturating); CNT_WIDTH must satisfy DEBOUNCE_CYCLES < 2^CNT_WIDTH.
- Downstream contract: config_out is always either 0 (before the first valid selection) or exactly one-hot. It never changes except on a config_strobe cycle.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, switch_raw=5'b11101 held -> config_out=5'b00010, config_strobe=1 for one cycle on edge 7 after reset release, config_valid=1, config_error=0.
- From 5'b00010 accepted, drive pin pattern for switch 4 (5'b10111) with 2-cycle bounce pulses back to 5'b11101 -> no strobe during bounce. config_out=5'b01000 exactly 7 edges after the last bounce, single strobe.
- Hold pattern for switches 1+3 (5'b11010) stable -> config_error=1 after 7 edges, config_out stays 5'b01000, config_valid=1, no strobe. Return to switch 4 -> config_error clears after 7 edges, no strobe.
- Glitch of 3 cycles (< DEBOUNCE_CYCLES) to switch 5 pattern -> config_out, config_strobe and config_error unchanged throughout.
- Assert reset for 1 cycle at cnt=2 of a new switch-3 selection -> all outputs 0 next cycle. config_out=5'b00100 and strobe appear 7 edges after reset release, never earlier.
- All switches off after reset -> config_error=1, config_valid=0, config_out=0 at edge 7. Strobe never asserted.
